// File: rtl/not_n_pipe_if.sv
// Valid/ready stream bundle for not_n_pipe: operand stream in, flagged result stream out.
// Carries out_par only when NOT_N_PIPE_PARITY_EN is defined.
interface not_n_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] in_mask;
   logic             in_zx;
   logic             in_nx;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zr;
   logic             out_ng;
`ifdef NOT_N_PIPE_PARITY_EN
   logic             out_par;
`endif

   modport master (
      output in_valid, in_data, in_mask, in_zx, in_nx, out_ready,
      input
`ifdef NOT_N_PIPE_PARITY_EN
             out_par,
`endif
             in_ready, out_valid, out_data, out_zr, out_ng
   );

   modport slave (
      input  in_valid, in_data, in_mask, in_zx, in_nx, out_ready,
      output
`ifdef NOT_N_PIPE_PARITY_EN
             out_par,
`endif
             in_ready, out_valid, out_data, out_zr, out_ng
   );
endinterface

// File: rtl/not_n_pipe.sv
// not_n_pipe: DEPTH-stage valid/ready pipeline computing optional zeroing plus masked inversion,
// with zero/negative flags and a handshake counter. NOT_N_PIPE_PARITY_EN adds out_par.
module not_n_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   not_n_pipe_if.slave      bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] txn_cnt
);
   typedef struct packed {
`ifdef NOT_N_PIPE_PARITY_EN
      logic             par;
`endif
      logic             zr;
      logic             ng;
      logic [WIDTH-1:0] data;
   } word_t;

   word_t            stg [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] adv;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] r;
   word_t            s0;
   logic             hs;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      s0      = '0;
      t       = bus.in_zx ? '0 : bus.in_data;
      r       = bus.in_nx ? (t ^ bus.in_mask) : t;
      s0.data = r;
      s0.zr   = (r == '0);
      s0.ng   = r[WIDTH-1];
`ifdef NOT_N_PIPE_PARITY_EN
      s0.par  = ^r;
`endif
   end

   // Ready ripples from the output back to the input; a stage moves if it is empty or its successor moves.
   always_comb begin : ready_chain
      logic go;
      adv          = '0;
      go           = !vld[DEPTH-1] || bus.out_ready;
      adv[DEPTH-1] = go;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         go     = !vld[k] || go;
         adv[k] = go;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         // NOTE: the data stages are reset too, because out_data and the flags must read 0 out of reset.
         for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
         if (adv[0]) begin
            vld[0] <= bus.in_valid;
            stg[0] <= s0;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
               vld[k] <= vld[k-1];
               stg[k] <= stg[k-1];
            end
         end
      end
   end

   assign hs = vld[DEPTH-1] && bus.out_ready;

   // A clear in the same cycle as a handshake wins; that handshake goes uncounted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       txn_cnt <= '0;
      else if (cnt_clr) txn_cnt <= '0;
      else if (hs)      txn_cnt <= txn_cnt + CNT_W'(1);
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = vld[DEPTH-1];
   assign bus.out_data  = stg[DEPTH-1].data;
   assign bus.out_zr    = stg[DEPTH-1].zr;
   assign bus.out_ng    = stg[DEPTH-1].ng;
`ifdef NOT_N_PIPE_PARITY_EN
   assign bus.out_par   = stg[DEPTH-1].par;
`endif
endmodule
